cache_control: RTL and testbench

- FSM that sequences the 2-way set-associative, write-back, write-allocate L1 cache datapath: 8 sets, 128-bit lines, 9-bit tags.
- Sits between the CPU memory port (mem_read/mem_write/mem_resp) and physical memory (pmem_read/pmem_write/pmem_resp).
- Drives every load, mux-select and bit-input control of the datapath, and decides hit, writeback and allocate sequencing.
- Holds saturating hit/miss/writeback performance counters for debug.

---
 rtl/lc3b_types.sv | 19 +
 rtl/sat_counter.sv | 33 +++
 rtl/cache_control.sv | 205 ++++++++++++++++++++
 tb/tb_cache_control.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared types for the LC-3b cache slice. Holds the cache
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

  // Controller sequencing states: service hits, write a dirty victim back,
  // then fetch the missing line.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

endpackage : lc3b_types
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk   - clock
//               reset - asynchronous active-high clear
//               inc   - count one event on this edge
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module      : cache_control
// Description : Control FSM for a 2-way set-associative, write-back,
//               write-allocate L1 cache datapath. Services hits in the
//               request cycle, writes back a dirty victim, fetches the
//               missing line, and keeps hit/miss/writeback counters.
// Ports       : clk, reset                - clock, async active-high reset
//               mem_read/mem_write/mem_resp - CPU request handshake
//               pmem_read/pmem_write/pmem_resp - physical memory handshake
//               hit, comp0, comp1, lru_out, d_out - datapath status
//               load_*, *_in, *_mux_sel   - datapath controls
//               hit_count, miss_count, wb_count - saturating counters
// Revision    : 1.0 - initial release
// ============================================================================
module cache_control
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  input  logic                 hit,
  input  logic                 comp0,
  input  logic                 comp1,
  input  logic                 lru_out,
  input  logic                 d_out,
  output logic                 load_v0,
  output logic                 load_v1,
  output logic                 load_d0,
  output logic                 load_d1,
  output logic                 load_tag0,
  output logic                 load_tag1,
  output logic                 load_data0,
  output logic                 load_data1,
  output logic                 load_lru,
  output logic                 v0_in,
  output logic                 v1_in,
  output logic                 d0_in,
  output logic                 d1_in,
  output logic                 lru_in,
  output logic                 data0_mux_sel,
  output logic                 data1_mux_sel,
  output logic                 data_mux_sel,
  output logic                 tag_mux_sel,
  output logic                 addr_mux_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  cache_state_t r_state;
  cache_state_t w_next_state;
  logic         r_refill;     // the coming IDLE hit is the refilled line
  logic         w_req;
  logic         w_hit_inc;
  logic         w_miss_inc;
  logic         w_wb_inc;

  // A simultaneous read and write is serviced as a write.
  assign w_req = mem_read | mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_refill <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_refill <= (r_state == ALLOCATE) && pmem_resp;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_req && !hit) begin
          w_next_state = d_out ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) begin
          w_next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (pmem_resp) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an in-flight pmem request
  // drops at once and no array sees a load pulse.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_v0       = 1'b0;
    load_v1       = 1'b0;
    load_d0       = 1'b0;
    load_d1       = 1'b0;
    load_tag0     = 1'b0;
    load_tag1     = 1'b0;
    load_data0    = 1'b0;
    load_data1    = 1'b0;
    load_lru      = 1'b0;
    v0_in         = 1'b0;
    v1_in         = 1'b0;
    d0_in         = 1'b0;
    d1_in         = 1'b0;
    lru_in        = 1'b0;
    data0_mux_sel = 1'b0;
    data1_mux_sel = 1'b0;
    data_mux_sel  = 1'b0;
    tag_mux_sel   = 1'b0;
    addr_mux_sel  = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_req && hit) begin
            mem_resp     = 1'b1;
            data_mux_sel = comp1;
            load_lru     = 1'b1;
            lru_in       = comp0;   // point LRU at the way not just used
            if (mem_write) begin
              if (comp0) begin
                load_data0 = 1'b1;
                load_d0    = 1'b1;
                d0_in      = 1'b1;
              end
              if (comp1) begin
                load_data1 = 1'b1;
                load_d1    = 1'b1;
                d1_in      = 1'b1;
              end
            end
          end
        end
        WRITEBACK: begin
          pmem_write   = 1'b1;
          addr_mux_sel = 1'b1;
          tag_mux_sel  = lru_out;
          data_mux_sel = lru_out;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            if (lru_out) begin
              load_data1    = 1'b1;
              data1_mux_sel = 1'b1;
              load_tag1     = 1'b1;
              load_v1       = 1'b1;
              v1_in         = 1'b1;
              load_d1       = 1'b1;
            end else begin
              load_data0    = 1'b1;
              data0_mux_sel = 1'b1;
              load_tag0     = 1'b1;
              load_v0       = 1'b1;
              v0_in         = 1'b1;
              load_d0       = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_hit_inc  = (r_state == IDLE) && w_req && hit && !r_refill;
  assign w_miss_inc = (r_state == IDLE) && w_req && !hit;
  assign w_wb_inc   = (r_state == WRITEBACK) && pmem_resp;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hit_inc),
    .count (hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_miss_inc),
    .count (miss_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wb_inc),
    .count (wb_count)
  );

endmodule : cache_control
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_control
// Description : Self-checking bench for cache_control. Expected control
//               vectors are queued as stimulus is applied and popped when
//               the outputs are sampled. A second instance with 2-bit
//               counters exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_control;

  logic clk = 1'b0;
  logic reset, mem_read, mem_write, pmem_resp, hit, comp0, comp1, lru_out, d_out;

  logic mem_resp, pmem_read, pmem_write;
  logic load_v0, load_v1, load_d0, load_d1, load_tag0, load_tag1;
  logic load_data0, load_data1, load_lru;
  logic v0_in, v1_in, d0_in, d1_in, lru_in;
  logic data0_mux_sel, data1_mux_sel, data_mux_sel, tag_mux_sel, addr_mux_sel;
  logic [15:0] hit_count, miss_count, wb_count;

  logic s_mem_resp, s_pmem_read, s_pmem_write;
  logic s_load_v0, s_load_v1, s_load_d0, s_load_d1, s_load_tag0, s_load_tag1;
  logic s_load_data0, s_load_data1, s_load_lru;
  logic s_v0_in, s_v1_in, s_d0_in, s_d1_in, s_lru_in;
  logic s_data0_mux_sel, s_data1_mux_sel, s_data_mux_sel, s_tag_mux_sel, s_addr_mux_sel;
  logic [1:0] s_hit_count, s_miss_count, s_wb_count;

  always #5 clk = ~clk;

  cache_control #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit(hit), .comp0(comp0), .comp1(comp1),
    .lru_out(lru_out), .d_out(d_out),
    .load_v0(load_v0), .load_v1(load_v1), .load_d0(load_d0), .load_d1(load_d1),
    .load_tag0(load_tag0), .load_tag1(load_tag1), .load_data0(load_data0),
    .load_data1(load_data1), .load_lru(load_lru),
    .v0_in(v0_in), .v1_in(v1_in), .d0_in(d0_in), .d1_in(d1_in), .lru_in(lru_in),
    .data0_mux_sel(data0_mux_sel), .data1_mux_sel(data1_mux_sel),
    .data_mux_sel(data_mux_sel), .tag_mux_sel(tag_mux_sel),
    .addr_mux_sel(addr_mux_sel),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  cache_control #(.CNT_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(s_mem_resp), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
    .pmem_resp(pmem_resp), .hit(hit), .comp0(comp0), .comp1(comp1),
    .lru_out(lru_out), .d_out(d_out),
    .load_v0(s_load_v0), .load_v1(s_load_v1), .load_d0(s_load_d0), .load_d1(s_load_d1),
    .load_tag0(s_load_tag0), .load_tag1(s_load_tag1), .load_data0(s_load_data0),
    .load_data1(s_load_data1), .load_lru(s_load_lru),
    .v0_in(s_v0_in), .v1_in(s_v1_in), .d0_in(s_d0_in), .d1_in(s_d1_in), .lru_in(s_lru_in),
    .data0_mux_sel(s_data0_mux_sel), .data1_mux_sel(s_data1_mux_sel),
    .data_mux_sel(s_data_mux_sel), .tag_mux_sel(s_tag_mux_sel),
    .addr_mux_sel(s_addr_mux_sel),
    .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count)
  );

  // All single-bit controls packed into one vector for comparison.
  logic [21:0] ctl;
  assign ctl = {mem_resp, pmem_read, pmem_write, load_v0, load_v1, load_d0, load_d1,
                load_tag0, load_tag1, load_data0, load_data1, load_lru,
                v0_in, v1_in, d0_in, d1_in, lru_in,
                data0_mux_sel, data1_mux_sel, data_mux_sel, tag_mux_sel, addr_mux_sel};

  localparam logic [21:0] C_MR   = 22'(1) << 21;
  localparam logic [21:0] C_PR   = 22'(1) << 20;
  localparam logic [21:0] C_PW   = 22'(1) << 19;
  localparam logic [21:0] C_LV0  = 22'(1) << 18;
  localparam logic [21:0] C_LV1  = 22'(1) << 17;
  localparam logic [21:0] C_LD0  = 22'(1) << 16;
  localparam logic [21:0] C_LD1  = 22'(1) << 15;
  localparam logic [21:0] C_LT0  = 22'(1) << 14;
  localparam logic [21:0] C_LT1  = 22'(1) << 13;
  localparam logic [21:0] C_LDA0 = 22'(1) << 12;
  localparam logic [21:0] C_LDA1 = 22'(1) << 11;
  localparam logic [21:0] C_LL   = 22'(1) << 10;
  localparam logic [21:0] C_V0I  = 22'(1) << 9;
  localparam logic [21:0] C_V1I  = 22'(1) << 8;
  localparam logic [21:0] C_D0I  = 22'(1) << 7;
  localparam logic [21:0] C_D1I  = 22'(1) << 6;
  localparam logic [21:0] C_LI   = 22'(1) << 5;
  localparam logic [21:0] C_D0M  = 22'(1) << 4;
  localparam logic [21:0] C_D1M  = 22'(1) << 3;
  localparam logic [21:0] C_DM   = 22'(1) << 2;
  localparam logic [21:0] C_TM   = 22'(1) << 1;
  localparam logic [21:0] C_AM   = 22'(1) << 0;

  // Refill of way 0 / way 1 on the ALLOCATE response cycle.
  localparam logic [21:0] C_FILL0 = C_PR | C_LDA0 | C_D0M | C_LT0 | C_LV0 | C_V0I | C_LD0;
  localparam logic [21:0] C_FILL1 = C_PR | C_LDA1 | C_D1M | C_LT1 | C_LV1 | C_V1I | C_LD1;

  // Stimulus byte: {mem_read, mem_write, hit, comp0, comp1, lru_out, d_out, pmem_resp}
  localparam logic [7:0] S_RD  = 8'h80;
  localparam logic [7:0] S_WR  = 8'h40;
  localparam logic [7:0] S_HIT = 8'h20;
  localparam logic [7:0] S_C0  = 8'h10;
  localparam logic [7:0] S_C1  = 8'h08;
  localparam logic [7:0] S_LRU = 8'h04;
  localparam logic [7:0] S_D   = 8'h02;
  localparam logic [7:0] S_PR  = 8'h01;

  typedef struct {
    string       name;
    logic [21:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic drive(input logic [7:0] s);
    @(negedge clk);
    {mem_read, mem_write, hit, comp0, comp1, lru_out, d_out, pmem_resp} = s;
  endtask

  task automatic test_reset();
    {mem_read, mem_write, hit, comp0, comp1, lru_out, d_out, pmem_resp} = 8'h00;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back('{"reset_ctl", 22'h0});
    #2;
    cur = exp_q.pop_front();
    n_cmp++;
    if (ctl !== cur.ctl) begin
      n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
    end
    n_cmp++;
    if ({hit_count, miss_count, wb_count} !== 48'h0) begin
      n_err++; $display("FAIL reset_counters: got %h/%h/%h expected 0/0/0", hit_count, miss_count, wb_count);
    end
    reset = 1'b0;
    drive(8'h00);
    exp_q.push_back('{"reset_idle", 22'h0});
    #2;
    cur = exp_q.pop_front();
    n_cmp++;
    if (ctl !== cur.ctl) begin
      n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
    end
  endtask

  task automatic test_clean_miss();
    logic [7:0]  st[5];
    logic [21:0] ev[5];
    st = '{S_RD, S_RD, S_RD, S_RD | S_PR, S_RD | S_HIT | S_C0};
    ev = '{22'h0, C_PR, C_PR, C_FILL0, C_MR | C_LL | C_LI};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp_q.push_back('{$sformatf("clean_miss[%0d]", i), ev[i]});
      #2;
      cur = exp_q.pop_front();
      n_cmp++;
      if (ctl !== cur.ctl) begin
        n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
      end
    end
    drive(8'h00);
    #2;
    n_cmp++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      n_err++; $display("FAIL clean_miss_counts: got hit=%0d miss=%0d expected hit=0 miss=1", hit_count, miss_count);
    end
  endtask

  task automatic test_hits();
    logic [7:0]  st[4];
    logic [21:0] ev[4];
    st = '{S_RD | S_HIT | S_C0, S_RD | S_HIT | S_C1 | S_LRU,
           S_WR | S_HIT | S_C0, S_RD | S_WR | S_HIT | S_C1};
    ev = '{C_MR | C_LL | C_LI, C_MR | C_LL | C_DM,
           C_MR | C_LL | C_LI | C_LDA0 | C_LD0 | C_D0I,
           C_MR | C_LL | C_DM | C_LDA1 | C_LD1 | C_D1I};
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      exp_q.push_back('{$sformatf("hit[%0d]", i), ev[i]});
      #2;
      cur = exp_q.pop_front();
      n_cmp++;
      if (ctl !== cur.ctl) begin
        n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
      end
    end
    drive(8'h00);
    #2;
    n_cmp++;
    if (hit_count !== 16'd4 || miss_count !== 16'd1) begin
      n_err++; $display("FAIL hit_counts: got hit=%0d miss=%0d expected hit=4 miss=1", hit_count, miss_count);
    end
  endtask

  task automatic test_dirty_miss();
    logic [7:0]  st[11];
    logic [21:0] ev[11];
    st = '{S_RD | S_LRU, S_RD | S_LRU | S_PR, S_RD | S_HIT | S_C1,
           S_RD | S_D, S_RD | S_D, S_RD | S_D, S_RD | S_D | S_PR,
           S_RD, S_RD | S_PR, S_RD | S_HIT | S_C0, S_PR};
    ev = '{22'h0, C_FILL1, C_MR | C_LL | C_DM,
           22'h0, C_PW | C_AM, C_PW | C_AM, C_PW | C_AM,
           C_PR, C_FILL0, C_MR | C_LL | C_LI, 22'h0};
    for (int i = 0; i < 11; i++) begin
      drive(st[i]);
      exp_q.push_back('{$sformatf("dirty_miss[%0d]", i), ev[i]});
      #2;
      cur = exp_q.pop_front();
      n_cmp++;
      if (ctl !== cur.ctl) begin
        n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
      end
    end
    drive(8'h00);
    #2;
    n_cmp++;
    if (hit_count !== 16'd4 || miss_count !== 16'd3 || wb_count !== 16'd1) begin
      n_err++; $display("FAIL dirty_miss_counts: got hit=%0d miss=%0d wb=%0d expected 4/3/1",
                        hit_count, miss_count, wb_count);
    end
  endtask

  task automatic test_drop_request();
    logic [7:0]  st[5];
    logic [21:0] ev[5];
    st = '{S_RD | S_LRU | S_D, S_LRU, S_LRU | S_PR, S_LRU | S_PR, 8'h00};
    ev = '{22'h0, C_PW | C_AM | C_TM | C_DM, C_PW | C_AM | C_TM | C_DM, C_FILL1, 22'h0};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp_q.push_back('{$sformatf("drop[%0d]", i), ev[i]});
      #2;
      cur = exp_q.pop_front();
      n_cmp++;
      if (ctl !== cur.ctl) begin
        n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
      end
    end
    n_cmp++;
    if (hit_count !== 16'd4 || miss_count !== 16'd4 || wb_count !== 16'd2) begin
      n_err++; $display("FAIL drop_counts: got hit=%0d miss=%0d wb=%0d expected 4/4/2",
                        hit_count, miss_count, wb_count);
    end
  endtask

  task automatic test_reset_mid_writeback();
    drive(S_RD | S_D);
    drive(S_RD | S_D);
    exp_q.push_back('{"rst_mid_before", C_PW | C_AM});
    #2;
    cur = exp_q.pop_front();
    n_cmp++;
    if (ctl !== cur.ctl) begin
      n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
    end
    #1 reset = 1'b1;
    exp_q.push_back('{"rst_mid_async", 22'h0});
    #1;
    cur = exp_q.pop_front();
    n_cmp++;
    if (ctl !== cur.ctl) begin
      n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
    end
    n_cmp++;
    if ({hit_count, miss_count, wb_count} !== 48'h0) begin
      n_err++; $display("FAIL rst_mid_counters: got %h/%h/%h expected 0/0/0", hit_count, miss_count, wb_count);
    end
    @(negedge clk);
    reset = 1'b0;
    {mem_read, mem_write, hit, comp0, comp1, lru_out, d_out, pmem_resp} = 8'h00;
    exp_q.push_back('{"rst_mid_idle", 22'h0});
    #2;
    cur = exp_q.pop_front();
    n_cmp++;
    if (ctl !== cur.ctl) begin
      n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
    end
    // A hit answers at once, so the FSM is back in IDLE.
    drive(S_RD | S_HIT | S_C0);
    exp_q.push_back('{"rst_mid_hit", C_MR | C_LL | C_LI});
    #2;
    cur = exp_q.pop_front();
    n_cmp++;
    if (ctl !== cur.ctl) begin
      n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
    end
    drive(8'h00);
  endtask

  task automatic test_saturate();
    int exp_cnt;
    @(negedge clk);
    reset = 1'b1;
    #2;
    n_cmp++;
    if (s_hit_count !== 2'd0) begin
      n_err++; $display("FAIL sat_reset: got %0d expected 0", s_hit_count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(S_RD | S_HIT | S_C0);
      exp_q.push_back('{$sformatf("sat_hit[%0d]", i), C_MR | C_LL | C_LI});
      #2;
      cur = exp_q.pop_front();
      n_cmp++;
      if (ctl !== cur.ctl) begin
        n_err++; $display("FAIL %s: got %h expected %h", cur.name, ctl, cur.ctl);
      end
      exp_cnt = (i > 3) ? 3 : i;
      n_cmp++;
      if (s_hit_count !== 2'(exp_cnt)) begin
        n_err++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, s_hit_count, exp_cnt);
      end
    end
    drive(8'h00);
    #2;
    n_cmp++;
    if (s_hit_count !== 2'd3 || hit_count !== 16'd5) begin
      n_err++; $display("FAIL sat_final: got small=%0d wide=%0d expected 3/5", s_hit_count, hit_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_clean_miss();
    test_hits();
    test_dirty_miss();
    test_drop_request();
    test_reset_mid_writeback();
    test_saturate();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cache_control
`default_nettype wire
